seq_det: RTL and testbench

- Serial bit-stream pattern detector, LSB-first; the stimulus side drives one bit per clock.
- Compares the most recent SEQ_LEN bits against a programmable PATTERN.
- Raises a registered one-cycle pulse on seq_detected when they match.
- Sits as the slave of the serial-data interface (ser_data in, seq_detected out).

---
 rtl/seq_det_pkg.sv | 24 ++
 rtl/seq_det_shreg.sv | 49 ++++
 rtl/seq_det.sv | 86 ++++++++
 tb/tb_seq_det.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// ============================================================================
// Module  : seq_det_pkg
// Brief   : Shared constants and helpers for the seq_det serial pattern detector.
// Revision: 1.0
// ============================================================================
`default_nettype none

package seq_det_pkg;

  localparam int         DEFAULT_SEQ_LEN = 8;
  localparam logic [7:0] DEFAULT_PATTERN = 8'hA5;
  localparam int         MATCH_CNT_W     = 16;

  localparam int DEFAULT_FILL_W = $clog2(DEFAULT_SEQ_LEN + 1);
  typedef logic [DEFAULT_FILL_W-1:0] fill_t;

  // Width that holds every fill count 0..seq_len inclusive.
  function automatic int fill_width(input int seq_len);
    return $clog2(seq_len + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_det_shreg.sv
// ============================================================================
// Module  : seq_det_shreg
// Brief   : LSB-first history shift register with saturating, flushable fill count.
// Revision: 1.0
// ============================================================================
`default_nettype none

module seq_det_shreg
  import seq_det_pkg::*;
#(
  parameter int SEQ_LEN = DEFAULT_SEQ_LEN,
  parameter int FILL_W  = fill_width(DEFAULT_SEQ_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               din,
  input  logic               flush,
  output logic [SEQ_LEN-1:0] hist_nxt,
  output logic [FILL_W-1:0]  fill_nxt
);

  localparam logic [FILL_W-1:0] C_FILL_MAX = FILL_W'(SEQ_LEN);

  logic [SEQ_LEN-1:0] r_hist;
  logic [FILL_W-1:0]  r_fill;
  logic               w_unused_hist_lsb;

  // fill_nxt is the pre-flush count so the comparator sees the count that
  // includes the bit being sampled on this edge.
  always_comb begin
    hist_nxt = {din, r_hist[SEQ_LEN-1:1]};
    fill_nxt = (r_fill == C_FILL_MAX) ? r_fill : r_fill + FILL_W'(1);
  end

  assign w_unused_hist_lsb = r_hist[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hist <= '0;
      r_fill <= '0;
    end else begin
      r_hist <= hist_nxt;
      r_fill <= flush ? '0 : fill_nxt;
    end
  end

endmodule

`default_nettype wire

// File: rtl/seq_det.sv
// ============================================================================
// Module  : seq_det
// Brief   : Serial LSB-first pattern detector with registered one-cycle match
//           pulse; optional saturating match counter under SEQ_DET_MATCH_CNT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module seq_det
  import seq_det_pkg::*;
#(
  parameter int                 SEQ_LEN = DEFAULT_SEQ_LEN,
  parameter logic [SEQ_LEN-1:0] PATTERN = SEQ_LEN'(DEFAULT_PATTERN),
  parameter int                 OVERLAP = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ser_data,
  output logic                   seq_detected
`ifdef SEQ_DET_MATCH_CNT_EN
  ,
  output logic [MATCH_CNT_W-1:0] match_cnt
`endif
);

  localparam int                FILL_W     = fill_width(SEQ_LEN);
  localparam logic [FILL_W-1:0] C_FILL_MAX = FILL_W'(SEQ_LEN);

  logic [SEQ_LEN-1:0] w_hist_nxt;
  logic [FILL_W-1:0]  w_fill_nxt;
  logic               w_match;
  logic               w_flush;
  logic               r_seq_detected;

  seq_det_shreg #(
    .SEQ_LEN (SEQ_LEN),
    .FILL_W  (FILL_W)
  ) u_shreg (
    .clk      (clk),
    .rst      (rst),
    .din      (ser_data),
    .flush    (w_flush),
    .hist_nxt (w_hist_nxt),
    .fill_nxt (w_fill_nxt)
  );

  // The fill qualifier keeps zero-filled history after reset from matching.
  assign w_match = (w_fill_nxt == C_FILL_MAX) && (w_hist_nxt == PATTERN);

  generate
    if (OVERLAP != 0) begin : g_overlap
      assign w_flush = 1'b0;
    end else begin : g_no_overlap
      assign w_flush = w_match;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seq_detected <= 1'b0;
    end else begin
      r_seq_detected <= w_match;
    end
  end

  assign seq_detected = r_seq_detected;

`ifdef SEQ_DET_MATCH_CNT_EN
  logic [MATCH_CNT_W-1:0] r_match_cnt;

  // Counts on the same edge that raises seq_detected, so the count already
  // includes a pulse while it is visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_match_cnt <= '0;
    end else if (w_match && (r_match_cnt != {MATCH_CNT_W{1'b1}})) begin
      r_match_cnt <= r_match_cnt + MATCH_CNT_W'(1);
    end
  end

  assign match_cnt = r_match_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_seq_det.sv
// ============================================================================
// Module  : tb_seq_det
// Brief   : Self-checking bench for seq_det; match-counter checks under SEQ_DET_MATCH_CNT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_seq_det;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ser_data = 1'b0;
  logic det_a5, det_ff1, det_ff0, det_00;
  logic [3:0] dets;

  always #5 clk = ~clk;

`ifdef SEQ_DET_MATCH_CNT_EN
  logic [15:0] cnt_a5, cnt_ff1, cnt_ff0, cnt_00;
`endif

  seq_det #(.SEQ_LEN(8), .PATTERN(8'hA5), .OVERLAP(1)) u_a5 (
    .clk(clk), .rst(rst), .ser_data(ser_data), .seq_detected(det_a5)
`ifdef SEQ_DET_MATCH_CNT_EN
    , .match_cnt(cnt_a5)
`endif
  );
  seq_det #(.SEQ_LEN(8), .PATTERN(8'hFF), .OVERLAP(1)) u_ff1 (
    .clk(clk), .rst(rst), .ser_data(ser_data), .seq_detected(det_ff1)
`ifdef SEQ_DET_MATCH_CNT_EN
    , .match_cnt(cnt_ff1)
`endif
  );
  seq_det #(.SEQ_LEN(8), .PATTERN(8'hFF), .OVERLAP(0)) u_ff0 (
    .clk(clk), .rst(rst), .ser_data(ser_data), .seq_detected(det_ff0)
`ifdef SEQ_DET_MATCH_CNT_EN
    , .match_cnt(cnt_ff0)
`endif
  );
  seq_det #(.SEQ_LEN(8), .PATTERN(8'h00), .OVERLAP(1)) u_00 (
    .clk(clk), .rst(rst), .ser_data(ser_data), .seq_detected(det_00)
`ifdef SEQ_DET_MATCH_CNT_EN
    , .match_cnt(cnt_00)
`endif
  );

  assign dets = {det_00, det_ff0, det_ff1, det_a5};

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: remembers the last 8 bits since reset and, per instance,
  // how many bits have arrived since reset or since its last flushing match.
  logic [7:0] pat [4] = '{8'hA5, 8'hFF, 8'hFF, 8'h00};
  bit         ovl [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
  bit         recent[$];
  int         valid [4];
  bit         exp_det [4];
  int         exp_cnt;
  logic [7:0] word;

  initial begin
    foreach (valid[k]) valid[k] = 0;
    foreach (exp_det[k]) exp_det[k] = 1'b0;
    exp_cnt = 0;
  end

  always @(posedge clk) begin
    if (rst) begin
      recent.delete();
      foreach (valid[k]) valid[k] = 0;
      foreach (exp_det[k]) exp_det[k] = 1'b0;
      exp_cnt = 0;
    end else begin
      recent.push_back(ser_data);
      if (recent.size() > 8) void'(recent.pop_front());
      word = 8'h00;
      if (recent.size() == 8)
        for (int i = 0; i < 8; i++) word[i] = recent[i];
      foreach (valid[k]) begin
        valid[k]++;
        exp_det[k] = (valid[k] >= 8) && (word == pat[k]);
        if (exp_det[k] && !ovl[k]) valid[k] = 0;
      end
      if (exp_det[0] && exp_cnt < 65535) exp_cnt++;
    end
    #1;
    chk("model_a5",  det_a5,  exp_det[0]);
    chk("model_ff1", det_ff1, exp_det[1]);
    chk("model_ff0", det_ff0, exp_det[2]);
    chk("model_00",  det_00,  exp_det[3]);
`ifdef SEQ_DET_MATCH_CNT_EN
    chk("model_cnt", cnt_a5, exp_cnt[15:0]);
`endif
  end

  task automatic send_bit(input bit b);
    @(negedge clk);
    rst = 1'b0;
    ser_data = b;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    ser_data = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Sends n bits of w LSB-first; after edge i, instance inst must equal expmask[i].
  task automatic send_word(input logic [31:0] w, input int n, input string name,
                           input int inst, input logic [31:0] expmask);
    for (int i = 0; i < n; i++) begin
      send_bit(w[i]);
      chk(name, dets[inst], expmask[i]);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_det", dets, 4'b0000);

    send_word(32'hA5, 8, "a5_single", 0, 32'h80);
    send_bit(1'b0);
    chk("a5_after", det_a5, 1'b0);

    do_reset;
    send_word(32'h5A00, 16, "no_match", 0, 32'h0);

    do_reset;
    send_word(32'hA5A5, 16, "a5_twice", 0, 32'h8080);

    do_reset;
    for (int i = 0; i < 16; i++) begin
      send_bit(1'b1);
      chk("ff_overlap",   det_ff1, (i >= 7));
      chk("ff_nooverlap", det_ff0, (i == 7) || (i == 15));
    end

    do_reset;
    send_word(32'h0, 8, "zero_pat", 3, 32'h80);

    do_reset;
    send_word(32'hA5, 5, "partial", 0, 32'h0);
    do_reset;
    send_word(32'hA5, 8, "after_rst", 0, 32'h80);

`ifdef SEQ_DET_MATCH_CNT_EN
    do_reset;
    send_word(32'hA5A5A5, 24, "cnt_seq", 0, 32'h808080);
    send_bit(1'b0);
    chk("match_cnt3", cnt_a5, 16'd3);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("match_cnt_async", cnt_a5, 16'd0);
`endif

    do_reset;
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 9))
        0: for (int i = 0; i < 8; i++) send_bit(i == 0 || i == 2 || i == 5 || i == 7);
        1: for (int i = 0; i < 8; i++) send_bit(1'b1);
        2: for (int i = 0; i < 8; i++) send_bit(1'b0);
        3: if ($urandom_range(0, 3) == 0) do_reset;
           else send_bit(1'($urandom_range(0, 1)));
        default: send_bit(1'($urandom_range(0, 1)));
      endcase
    end
    send_bit(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
